// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUOp,
// ALUSrcB/PCSource selects, FSM state enum and the control payload struct.
package mips_ctrl_pkg;

  localparam int unsigned OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0c;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0d;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'h0f;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2b;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_NOR   = 3'b010;
  localparam logic [2:0] ALU_ADD   = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;
  localparam logic [2:0] ALU_JAL   = 3'b110;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_RTYPE_EX, S_ALUWB, S_IMM_EX, S_IMMWB, S_BRANCH, S_JUMP, S_JAL_WB
  } state_e;

  // Every datapath control plus the two status pulses, before reset gating.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       zero_imm;
    logic       lui;
    logic       jump_and_link;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // States that perform a memory access and therefore use the wait timer.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory access completion: either the mem_ready handshake or a fixed
// MEM_LAT-cycle count restarted on every entry into a memory state.
// Ports: clk, reset (async active-low), enter_i (next cycle is a fresh memory
// state), in_mem_i (currently in a memory state), mem_ready_i, done_acc_o.
module mem_wait_timer #(
  parameter int unsigned USE_MEM_READY = 1,
  parameter int unsigned MEM_LAT       = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enter_i,
  input  logic in_mem_i,
  input  logic mem_ready_i,
  output logic done_acc_o
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear on entry, count while waiting, saturate at the final access cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (enter_i) begin
      cnt_d = '0;
    end else if (in_mem_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_acc_o = (USE_MEM_READY != 0) ? mem_ready_i : (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Opcode-driven control FSM for the multicycle MIPS datapath.
// Ports: clk, reset (async active-low), OP (IR opcode), mem_ready (access
// handshake); datapath controls IorD..JumpAndLink, ALUSrcB, PCSource, ALUOp;
// status instr_done (last cycle of an instruction), illegal_op (unknown
// opcode in DECODE) and instr_count (retired instructions, wrapping).
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OP_W          = 6,
  parameter int unsigned ALUOP_W       = 3,
  parameter int unsigned USE_MEM_READY = 1,
  parameter int unsigned MEM_LAT       = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    OP,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               PCWrite,
  output logic               BranchEQ,
  output logic               BranchNE,
  output logic               ZeroImm,
  output logic               LUI,
  output logic               JumpAndLink,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   instr_count
);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            ctl_c;
  logic             done_acc;
  logic             enter_mem;
  logic             in_mem;
  logic [2:0]       imm_alu_op;
  logic             imm_zero;
  logic             imm_lui;

  assign in_mem    = is_mem_state(state_q);
  assign enter_mem = is_mem_state(state_d) && (state_d != state_q);

  mem_wait_timer #(
    .USE_MEM_READY(USE_MEM_READY),
    .MEM_LAT      (MEM_LAT)
  ) u_wait (
    .clk        (clk),
    .reset      (reset),
    .enter_i    (enter_mem),
    .in_mem_i   (in_mem),
    .mem_ready_i(mem_ready),
    .done_acc_o (done_acc)
  );

  // Immediate-class ALU setup, shared by IMM_EX and IMMWB.
  always_comb begin
    imm_alu_op = ALU_ADD;
    imm_zero   = 1'b0;
    imm_lui    = 1'b0;
    if (op_q == OP_W'(OP_ORI)) begin
      imm_alu_op = ALU_OR;
      imm_zero   = 1'b1;
    end else if (op_q == OP_W'(OP_ANDI)) begin
      imm_alu_op = ALU_AND;
      imm_zero   = 1'b1;
    end else if (op_q == OP_W'(OP_LUI)) begin
      imm_alu_op = ALU_LUI;
      imm_lui    = 1'b1;
    end
  end

  // Next state and Moore controls; only FETCH/MEMWRITE strobes see done_acc.
  always_comb begin
    state_d = state_q;
    ctl_c   = '0;
    unique case (state_q)
      S_FETCH: begin
        ctl_c.mem_read  = 1'b1;
        ctl_c.alu_src_b = SRCB_FOUR;
        ctl_c.alu_op    = ALU_ADD;
        ctl_c.ir_write  = done_acc;
        ctl_c.pc_write  = done_acc;
        if (done_acc) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctl_c.alu_src_b = SRCB_BR;
        ctl_c.alu_op    = ALU_ADD;
        // Live OP here; op_q captures it on this same edge.
        case (OP)
          OP_W'(OP_RTYPE):                 state_d = S_RTYPE_EX;
          OP_W'(OP_LW), OP_W'(OP_SW):      state_d = S_MEMADR;
          OP_W'(OP_ADDI), OP_W'(OP_ORI),
          OP_W'(OP_ANDI), OP_W'(OP_LUI):   state_d = S_IMM_EX;
          OP_W'(OP_BEQ), OP_W'(OP_BNE):    state_d = S_BRANCH;
          OP_W'(OP_J):                     state_d = S_JUMP;
          OP_W'(OP_JAL):                   state_d = S_JAL_WB;
          default: begin
            ctl_c.illegal_op = 1'b1;
            state_d          = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        ctl_c.alu_op    = ALU_ADD;
        state_d = (op_q == OP_W'(OP_SW)) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctl_c.iord     = 1'b1;
        ctl_c.mem_read = 1'b1;
        if (done_acc) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctl_c.mem_to_reg = 1'b1;
        ctl_c.reg_write  = 1'b1;
        ctl_c.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        ctl_c.iord       = 1'b1;
        ctl_c.mem_write  = 1'b1;
        ctl_c.instr_done = done_acc;
        if (done_acc) state_d = S_FETCH;
      end
      S_RTYPE_EX: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_REG;
        ctl_c.alu_op    = ALU_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ctl_c.reg_dst    = 1'b1;
        ctl_c.reg_write  = 1'b1;
        ctl_c.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_IMM_EX, S_IMMWB: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        ctl_c.alu_op    = imm_alu_op;
        ctl_c.zero_imm  = imm_zero;
        ctl_c.lui       = imm_lui;
        if (state_q == S_IMMWB) begin
          ctl_c.reg_write  = 1'b1;
          ctl_c.instr_done = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_IMMWB;
        end
      end
      S_BRANCH: begin
        ctl_c.alu_src_a  = 1'b1;
        ctl_c.alu_src_b  = SRCB_REG;
        ctl_c.alu_op     = ALU_SUB;
        ctl_c.pc_source  = PCS_ALUOUT;
        ctl_c.branch_eq  = (op_q == OP_W'(OP_BEQ));
        ctl_c.branch_ne  = (op_q == OP_W'(OP_BNE));
        ctl_c.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        ctl_c.pc_source  = PCS_JUMP;
        ctl_c.pc_write   = 1'b1;
        ctl_c.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL_WB: begin
        ctl_c.pc_source     = PCS_JUMP;
        ctl_c.pc_write      = 1'b1;
        ctl_c.reg_write     = 1'b1;
        ctl_c.jump_and_link = 1'b1;
        ctl_c.alu_op        = ALU_JAL;
        ctl_c.instr_done    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= OP;
      if (ctl_c.instr_done) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Reset blanks every output immediately, aborting any strobe in flight.
  assign IorD        = reset & ctl_c.iord;
  assign MemRead     = reset & ctl_c.mem_read;
  assign MemWrite    = reset & ctl_c.mem_write;
  assign IRWrite     = reset & ctl_c.ir_write;
  assign RegDst      = reset & ctl_c.reg_dst;
  assign MemtoReg    = reset & ctl_c.mem_to_reg;
  assign RegWrite    = reset & ctl_c.reg_write;
  assign ALUSrcA     = reset & ctl_c.alu_src_a;
  assign PCWrite     = reset & ctl_c.pc_write;
  assign BranchEQ    = reset & ctl_c.branch_eq;
  assign BranchNE    = reset & ctl_c.branch_ne;
  assign ZeroImm     = reset & ctl_c.zero_imm;
  assign LUI         = reset & ctl_c.lui;
  assign JumpAndLink = reset & ctl_c.jump_and_link;
  assign ALUSrcB     = reset ? ctl_c.alu_src_b : 2'b00;
  assign PCSource    = reset ? ctl_c.pc_source : 2'b00;
  assign ALUOp       = reset ? ALUOP_W'(ctl_c.alu_op) : '0;
  assign instr_done  = reset & ctl_c.instr_done;
  assign illegal_op  = reset & ctl_c.illegal_op;
  assign instr_count = reset ? cnt_q : '0;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Opcode-driven control FSM for the multicycle MIPS datapath; successor to the single-cycle control decoder.
- Same opcode set and 3-bit ALUOp encoding, spread over per-instruction state sequences.
- Memory accesses complete on a ready handshake or after a parametrised fixed latency.
- Sits between the IR opcode field and the datapath muxes, register enables and PC write strobes; also keeps a retired-instruction counter.

Parameters:
OP_W, 6, opcode width (Instruction[31:26])
ALUOP_W, 3, ALUOp width
USE_MEM_READY, 1, 1 = memory states wait for mem_ready; 0 = fixed latency
MEM_LAT, 1, access cycles when USE_MEM_READY=0 (>=1)
CNT_W, 32, width of instr_count

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
OP  in  OP_W  opcode from IR, stable from DECODE until instruction end
mem_ready  in  1  memory access completes this cycle (used when USE_MEM_READY=1)
IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite, BranchEQ, BranchNE, ZeroImm, LUI, JumpAndLink  out  1 each  datapath controls
ALUSrcB  out  2  00 reg B, 01 const 4, 10 ext imm, 11 sext imm<<2
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
ALUOp  out  ALUOP_W  000 AND, 001 OR, 010 NOR, 011 ADD, 100 SUB, 101 LUI, 110 JAL, 111 FUNCT
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal_op  out  1  one-cycle pulse in DECODE for an unknown opcode
instr_count  out  CNT_W  instructions retired, wraps modulo 2^CNT_W

Behaviour:
- Reset: clk and reset are the single clock and the asynchronous active-low reset.
  - While reset=0: state=FETCH, wait counter=0, instr_count=0.
  - While reset=0, every output is forced 0 combinationally.
  - Reset mid-instruction aborts it; no strobes fire.
- Outputs not listed for a state are 0. All outputs are Moore except the access-complete qualified strobes below.
- done_acc: mem_ready when USE_MEM_READY=1; otherwise wait counter == MEM_LAT-1.
- Wait counter:
  - clears on entry to any memory state (FETCH, MEMREAD, MEMWRITE);
  - increments each cycle while in that state, saturating at MEM_LAT-1.
- States (next state in brackets):
  - FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD. IRWrite=PCWrite=done_acc. [DECODE on done_acc, else FETCH]
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD.
    - R 0x00 -> RTYPE_EX
    - LW 0x23 / SW 0x2b -> MEMADR
    - ADDI 0x08 / ORI 0x0d / ANDI 0x0c / LUI 0x0f -> IMM_EX
    - BEQ 0x04 / BNE 0x05 -> BRANCH
    - J 0x02 -> JUMP
    - JAL 0x03 -> JAL_WB
    - other -> FETCH with illegal_op=1 (instr_done=0, not counted)
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. [MEMREAD for LW, MEMWRITE for SW]
  - MEMREAD: IorD=1, MemRead=1. [MEMWB on done_acc]
  - MEMWB: MemtoReg=1, RegWrite=1, RegDst=0. [FETCH]
  - MEMWRITE: IorD=1, MemWrite=1. [FETCH on done_acc]
  - RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=111. [ALUWB]
  - ALUWB: RegDst=1, RegWrite=1. [FETCH]
  - IMM_EX: ALUSrcA=1, ALUSrcB=10.
    - ALUOp: ADD for ADDI, OR for ORI, AND for ANDI, LUI for LUI.
    - ZeroImm=1 for ORI/ANDI; LUI=1 for LUI. [IMMWB]
  - IMMWB: holds the IMM_EX ALU controls; RegDst=0, RegWrite=1. [FETCH]
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01, BranchEQ (BEQ) or BranchNE (BNE). [FETCH]
  - JUMP: PCSource=10, PCWrite=1. [FETCH]
  - JAL_WB: PCSource=10, PCWrite=1, RegWrite=1, JumpAndLink=1, ALUOp=JAL. [FETCH]
- Opcode latch: OP is latched into op_q on the DECODE cycle. Every later state decodes op_q, never live OP.
- instr_done: 1 in any cycle whose next state is FETCH, except from FETCH itself and the illegal path. instr_count increments on the same edge.
- Fixed-latency cycle counts with MEM_LAT=1: LW 5, SW 4, R/IMM 4, BEQ/BNE/J/JAL 3. Each memory state adds MEM_LAT-1 cycles.
- mem_ready never high: the FSM holds in the memory state indefinitely with outputs stable.

Decomposition:
- Package mips_ctrl_pkg: opcode localparams, ALUOp encodings, ALUSrcB/PCSource encodings, state enum.
- Sub-module mem_wait_timer: wait counter plus done_acc generation, parametrised by USE_MEM_READY and MEM_LAT.

Test Plan:
- Reset release, OP=0x23, MEM_LAT=1, USE_MEM_READY=0 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. MemtoReg=RegWrite=1 in cycle 5; instr_done pulse; instr_count=1.
- OP=0x04, USE_MEM_READY=1, mem_ready high on 3rd FETCH cycle -> IRWrite=PCWrite only in that cycle. BRANCH shows ALUOp=100, BranchEQ=1, PCSource=01.
- OP=0x0d -> IMM_EX: ALUOp=001, ZeroImm=1. IMMWB: RegWrite=1, RegDst=0. OP changed to 0x00 after DECODE has no effect.
- OP=0x03 -> JAL_WB: PCSource=10, PCWrite=RegWrite=JumpAndLink=1, ALUOp=110. Then FETCH.
- OP=0x3f -> illegal_op pulse in DECODE, back to FETCH, instr_count unchanged.
- reset low during MEMWRITE with mem_ready=0 -> all outputs 0 immediately. After release: FETCH, instr_count=0, no MemWrite.
